// File: rtl/sort_frame_ctrl.sv
// sort_frame_ctrl: sequencer between a valid/ready word stream and one parallel
// sorting network. Collects up to N = 2**LOG_INPUT_NUM words into a frame,
// pads unused slots so they sort to the tail, issues one network request,
// waits for the result and streams the sorted words back out with a last marker.
//
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   in_data/valid/last    input word stream, in_ready back-pressure
//   out_data/valid/last   sorted word stream, out_ready back-pressure
//   net_x, net_x_valid    packed network operand (slot j = word j) and request pulse
//   net_y, net_y_valid    packed network result and its valid strobe
//   busy                  high unless idle in LOAD with an empty frame
//   err                   sticky watchdog flag
//
// Optional feature: define SORT_TIMEOUT_EN to enable a WAIT-state watchdog of
// TIMEOUT cycles; without it WAIT waits indefinitely and err is tied low.
module sort_frame_ctrl #(
  parameter int unsigned LOG_INPUT_NUM = 4,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter bit          ASCENDING     = 1'b1,
  parameter int unsigned TIMEOUT       = 1024
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [DATA_WIDTH-1:0]                      in_data,
  input  logic                                       in_valid,
  input  logic                                       in_last,
  output logic                                       in_ready,
  output logic [DATA_WIDTH-1:0]                      out_data,
  output logic                                       out_valid,
  output logic                                       out_last,
  input  logic                                       out_ready,
  output logic [DATA_WIDTH*(2**LOG_INPUT_NUM)-1:0]   net_x,
  output logic                                       net_x_valid,
  input  logic [DATA_WIDTH*(2**LOG_INPUT_NUM)-1:0]   net_y,
  input  logic                                       net_y_valid,
  output logic                                       busy,
  output logic                                       err
);

  localparam int unsigned N  = 2**LOG_INPUT_NUM;
  localparam int unsigned CW = LOG_INPUT_NUM;
  localparam int unsigned LW = LOG_INPUT_NUM + 1;

  // Pads must sort behind every real word, so they take the extreme value.
  localparam logic [DATA_WIDTH-1:0] PAD = ASCENDING ? {DATA_WIDTH{1'b1}} : {DATA_WIDTH{1'b0}};

  localparam logic [1:0] ST_LOAD  = 2'd0;
  localparam logic [1:0] ST_KICK  = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  // Elaboration-time parameter sanity check.
  if (LOG_INPUT_NUM == 0 || TIMEOUT == 0) begin : g_param_check
    $error("sort_frame_ctrl: LOG_INPUT_NUM and TIMEOUT must be non-zero");
  end

  typedef logic [N-1:0][DATA_WIDTH-1:0] frame_t;

  logic [1:0]            state_q, state_d;
  logic [CW-1:0]         count_q, count_d;
  logic [LW-1:0]         len_q, len_d;
  logic [CW-1:0]         rd_idx_q, rd_idx_d;
  frame_t                frame_q, frame_d;
  frame_t                obuf_q, obuf_d;
  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q, out_last_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  net_x_valid_q, net_x_valid_d;
  logic                  busy_q, busy_d;
  logic                  in_fire, out_fire;
  logic [CW-1:0]         rd_idx_nxt;

`ifdef SORT_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;
`endif

  assign in_fire    = in_valid & in_ready_q;
  assign out_fire   = out_valid_q & out_ready;
  assign rd_idx_nxt = rd_idx_q + CW'(1);

  // Next-state and datapath update.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    len_d      = len_q;
    rd_idx_d   = rd_idx_q;
    frame_d    = frame_q;
    obuf_d     = obuf_q;
    out_data_d = out_data_q;
    out_last_d = out_last_q;
`ifdef SORT_TIMEOUT_EN
    tmo_d      = tmo_q;
    err_d      = err_q;
`endif

    case (state_q)
      ST_LOAD: begin
        if (in_fire) begin
          // First word of a frame pre-fills every other slot with PAD, so
          // slots at or beyond len hold PAD when the request is issued.
          if (count_q == '0) begin
            frame_d = {N{PAD}};
          end
          frame_d[count_q] = in_data;
          count_d          = count_q + CW'(1);
          if (in_last || (count_q == CW'(N - 1))) begin
            len_d   = LW'(count_q) + LW'(1);
            count_d = '0;
            state_d = ST_KICK;
          end
        end
      end

      ST_KICK: begin
        state_d = ST_WAIT;
`ifdef SORT_TIMEOUT_EN
        tmo_d   = '0;
`endif
      end

      ST_WAIT: begin
        if (net_y_valid) begin
          obuf_d     = net_y;
          rd_idx_d   = '0;
          out_data_d = net_y[DATA_WIDTH-1:0];
          out_last_d = (len_q == LW'(1));
          state_d    = ST_DRAIN;
        end
`ifdef SORT_TIMEOUT_EN
        else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          count_d = '0;
          state_d = ST_LOAD;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
`endif
      end

      ST_DRAIN: begin
        if (out_fire) begin
          if (out_last_q) begin
            out_last_d = 1'b0;
            state_d    = ST_LOAD;
          end else begin
            // Present the following word in the same edge as the handshake.
            rd_idx_d   = rd_idx_nxt;
            out_data_d = obuf_q[rd_idx_nxt];
            out_last_d = ((LW'(rd_idx_q) + LW'(2)) == len_q);
          end
        end
      end

      default: state_d = ST_LOAD;
    endcase

    in_ready_d    = (state_d == ST_LOAD);
    out_valid_d   = (state_d == ST_DRAIN);
    net_x_valid_d = (state_d == ST_KICK);
    busy_d        = !((state_d == ST_LOAD) && (count_d == '0));
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q       <= '0;
      len_q         <= '0;
      rd_idx_q      <= '0;
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
      out_data_q    <= '0;
      net_x_valid_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      count_q       <= count_d;
      len_q         <= len_d;
      rd_idx_q      <= rd_idx_d;
      in_ready_q    <= in_ready_d;
      out_valid_q   <= out_valid_d;
      out_last_q    <= out_last_d;
      out_data_q    <= out_data_d;
      net_x_valid_q <= net_x_valid_d;
      busy_q        <= busy_d;
    end
  end

  // Frame and result buffers carry no reset; their contents are qualified by state.
  always_ff @(posedge clk) begin
    frame_q <= frame_d;
    obuf_q  <= obuf_d;
  end

`ifdef SORT_TIMEOUT_EN
  // WAIT watchdog and sticky error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign in_ready    = in_ready_q;
  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign out_last    = out_last_q;
  assign net_x       = frame_q;
  assign net_x_valid = net_x_valid_q;
  assign busy        = busy_q;

endmodule
